// File: rtl/corr_peak_finder.sv
// -----------------------------------------------------------------------------
// corr_peak_finder
//
// Purpose:
//   Sits behind the four-lane SIMD pair-sum adder stage of the dual-RITC
//   correlator. Every valid cycle it picks the largest of the four 13-bit pair
//   sums. Over a programmable window of valid samples it tracks the running
//   maximum. At the end of the window it reports the peak value, the lane, the
//   sample index and a threshold flag to the trigger logic.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST_n        in   asynchronous active-low reset
//   APB/CPD/EPF/GPH in 13-bit unsigned lane sums (lane 0..3)
//   IN_VALID     in   lane sums valid this cycle
//   START        in   begin a window (honoured only while idle)
//   WINDOW_LEN   in   samples per window, latched at START (0 = 2^CNT_BITS)
//   THRESHOLD    in   peak threshold, latched at START
//   BUSY         out  window in progress or draining
//   PEAK_VALID   out  one-cycle strobe, PEAK_* / ABOVE_THRESH updated
//   PEAK_VALUE   out  maximum sum in the window
//   PEAK_LANE    out  lane of the maximum
//   PEAK_CYCLE   out  0-based valid-sample index of the maximum
//   ABOVE_THRESH out  PEAK_VALUE >= latched threshold
//
// Latency: last sample accepted at edge E -> PEAK_VALID high after edge E+2.
// -----------------------------------------------------------------------------
module corr_peak_finder #(
  parameter int CNT_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic [12:0]         APB,
  input  logic [12:0]         CPD,
  input  logic [12:0]         EPF,
  input  logic [12:0]         GPH,
  input  logic                IN_VALID,
  input  logic                START,
  input  logic [CNT_BITS-1:0] WINDOW_LEN,
  input  logic [12:0]         THRESHOLD,
  output logic                BUSY,
  output logic                PEAK_VALID,
  output logic [12:0]         PEAK_VALUE,
  output logic [1:0]          PEAK_LANE,
  output logic [CNT_BITS-1:0] PEAK_CYCLE,
  output logic                ABOVE_THRESH
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_BITS-1:0] r_last_idx;   // WINDOW_LEN-1; wraps to all-ones for LEN=0
  logic [12:0]         r_thresh;
  logic [CNT_BITS-1:0] r_count;

  // Stage 1: per-sample lane maximum
  logic                r_s1_valid;
  logic                r_s1_last;
  logic                r_s1_first;
  logic [12:0]         r_s1_val;
  logic [1:0]          r_s1_lane;
  logic [CNT_BITS-1:0] r_s1_idx;

  // Stage 2: running maximum over the window
  logic                r_s2_last;
  logic [12:0]         r_max_val;
  logic [1:0]          r_max_lane;
  logic [CNT_BITS-1:0] r_max_idx;

  // ---------------------------------------------------------------------------
  // Combinational lane compare tree
  // ---------------------------------------------------------------------------
  logic [12:0] w_lane [4];
  logic [12:0] w_pair_val [2];
  logic        w_pair_hi [2];     // 1 when the odd lane of the pair won
  logic        w_low_pair_wins;
  logic [12:0] w_best_val;
  logic [1:0]  w_best_lane;
  logic        w_start_ok;
  logic        w_accept;
  logic        w_last;

  assign w_lane[0] = APB;
  assign w_lane[1] = CPD;
  assign w_lane[2] = EPF;
  assign w_lane[3] = GPH;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      // Odd lane only wins when strictly greater, so ties go to the lower lane.
      assign w_pair_hi[gi]  = (w_lane[2*gi+1] > w_lane[2*gi]);
      assign w_pair_val[gi] = w_pair_hi[gi] ? w_lane[2*gi+1] : w_lane[2*gi];
    end
  endgenerate

  // Lower pair (lanes 0/1) keeps ties against the upper pair.
  assign w_low_pair_wins = (w_pair_val[0] >= w_pair_val[1]);
  assign w_best_val      = w_low_pair_wins ? w_pair_val[0] : w_pair_val[1];
  assign w_best_lane     = w_low_pair_wins ? {1'b0, w_pair_hi[0]}
                                           : {1'b1, w_pair_hi[1]};

  assign w_start_ok = (r_state == ST_IDLE) && START;
  assign w_accept   = (r_state == ST_ACCUM) && IN_VALID;
  assign w_last     = (r_count == r_last_idx);

  // ---------------------------------------------------------------------------
  // Control FSM with registered status and result outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state      <= ST_IDLE;
      r_last_idx   <= '0;
      r_thresh     <= '0;
      r_count      <= '0;
      BUSY         <= 1'b0;
      PEAK_VALID   <= 1'b0;
      PEAK_VALUE   <= '0;
      PEAK_LANE    <= '0;
      PEAK_CYCLE   <= '0;
      ABOVE_THRESH <= 1'b0;
    end else begin
      PEAK_VALID <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_last_idx <= WINDOW_LEN - CNT_ONE;
            r_thresh   <= THRESHOLD;
            r_count    <= '0;
            r_state    <= ST_ACCUM;
            BUSY       <= 1'b1;
          end
        end
        ST_ACCUM: begin
          // Gaps in IN_VALID just stall the count; no timeout.
          if (IN_VALID) begin
            r_count <= r_count + CNT_ONE;
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Running max is final once the last-tagged sample leaves stage 2.
          if (r_s2_last) begin
            PEAK_VALUE   <= r_max_val;
            PEAK_LANE    <= r_max_lane;
            PEAK_CYCLE   <= r_max_idx;
            ABOVE_THRESH <= (r_max_val >= r_thresh);
            PEAK_VALID   <= 1'b1;
            r_state      <= ST_IDLE;
            BUSY         <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: register the per-sample lane maximum and its tags
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_val   <= '0;
      r_s1_lane  <= '0;
      r_s1_idx   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_val   <= w_best_val;
        r_s1_lane  <= w_best_lane;
        r_s1_idx   <= r_count;
        r_s1_first <= (r_count == '0);
        r_s1_last  <= w_last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: running maximum. The first sample of a window loads
  // unconditionally; later samples replace only when strictly greater so
  // the earliest of equal peaks is reported.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_s2_last  <= 1'b0;
      r_max_val  <= '0;
      r_max_lane <= '0;
      r_max_idx  <= '0;
    end else begin
      r_s2_last <= r_s1_valid && r_s1_last;
      if (w_start_ok) begin
        r_max_val  <= '0;
        r_max_lane <= '0;
        r_max_idx  <= '0;
      end else if (r_s1_valid && (r_s1_first || (r_s1_val > r_max_val))) begin
        r_max_val  <= r_s1_val;
        r_max_lane <= r_s1_lane;
        r_max_idx  <= r_s1_idx;
      end
    end
  end

endmodule

// File: tb/tb_corr_peak_finder.sv
// -----------------------------------------------------------------------------
// tb_corr_peak_finder
//
// Directed, table-driven bench for corr_peak_finder. A table of windows with
// hand-computed peaks is replayed in a loop; reset, maximum-length window,
// back-to-back START and mid-window abort are hand-written sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_corr_peak_finder;

  typedef logic [3:0][12:0] lanes_t;

  typedef struct packed {
    logic [7:0]        len;
    logic [12:0]       thr;
    logic [2:0]        n;            // number of valid samples to drive
    lanes_t [3:0]      s;            // s[k][lane]
    logic [3:0][1:0]   gap;          // idle cycles before sample k
    logic              start_in_gap; // pulse START (with WINDOW_LEN=1) in gaps
    logic [12:0]       ev;
    logic [1:0]        el;
    logic [7:0]        ec;
    logic              ea;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic [12:0] APB = '0, CPD = '0, EPF = '0, GPH = '0;
  logic        IN_VALID = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  WINDOW_LEN = '0;
  logic [12:0] THRESHOLD = '0;
  logic        BUSY;
  logic        PEAK_VALID;
  logic [12:0] PEAK_VALUE;
  logic [1:0]  PEAK_LANE;
  logic [7:0]  PEAK_CYCLE;
  logic        ABOVE_THRESH;

  int checks = 0;
  int errors = 0;

  corr_peak_finder #(.CNT_BITS(8)) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .APB          (APB),
    .CPD          (CPD),
    .EPF          (EPF),
    .GPH          (GPH),
    .IN_VALID     (IN_VALID),
    .START        (START),
    .WINDOW_LEN   (WINDOW_LEN),
    .THRESHOLD    (THRESHOLD),
    .BUSY         (BUSY),
    .PEAK_VALID   (PEAK_VALID),
    .PEAK_VALUE   (PEAK_VALUE),
    .PEAK_LANE    (PEAK_LANE),
    .PEAK_CYCLE   (PEAK_CYCLE),
    .ABOVE_THRESH (ABOVE_THRESH)
  );

  always #5 CLK = ~CLK;

  function automatic lanes_t l4(input logic [12:0] a, input logic [12:0] b,
                                input logic [12:0] c, input logic [12:0] d);
    lanes_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_lanes(input lanes_t l);
    APB = l[0]; CPD = l[1]; EPF = l[2]; GPH = l[3];
  endtask

  // Waits (bounded) for PEAK_VALID; returns edges elapsed since the call.
  task automatic wait_peak(output int lat);
    lat = 0;
    while (!PEAK_VALID && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [12:0] ev,
                              input logic [1:0] el, input logic [7:0] ec,
                              input logic ea);
    int lat;
    wait_peak(lat);
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_busy_low"}, BUSY, 1'b0);
    chk({tag, "_value"}, PEAK_VALUE, ev);
    chk({tag, "_lane"}, PEAK_LANE, el);
    chk({tag, "_cycle"}, PEAK_CYCLE, ec);
    chk({tag, "_above"}, ABOVE_THRESH, ea);
    $display("%s: value=%0h lane=%0d cycle=%0d above=%0b latency=%0d",
             tag, PEAK_VALUE, PEAK_LANE, PEAK_CYCLE, ABOVE_THRESH, lat);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    START = 1'b1; WINDOW_LEN = v.len; THRESHOLD = v.thr; IN_VALID = 1'b0;
    tick();
    START = 1'b0;
    chk({tag, "_busy_start"}, BUSY, 1'b1);
    for (int k = 0; k < int'(v.n); k++) begin
      IN_VALID = 1'b0;
      for (int g = 0; g < int'(v.gap[k]); g++) begin
        if (v.start_in_gap) begin
          START = 1'b1;
          WINDOW_LEN = 8'd1;
        end
        tick();
      end
      START = 1'b0;
      drive_lanes(v.s[k]);
      IN_VALID = 1'b1;
      tick();
    end
    IN_VALID = 1'b0;
    drive_lanes('0);
    check_result(tag, v.ev, v.el, v.ec, v.ea);
    tick();
    chk({tag, "_strobe_drop"}, PEAK_VALID, 1'b0);
    chk({tag, "_value_hold"}, PEAK_VALUE, v.ev);
  endtask

  vec_t vecs [7];

  initial begin
    vec_t v;
    int   seen_pv;
    int   seen_busy;
    int   seen_out;

    // ---------------- vector table ----------------
    // 0: basic window, peak on EPF in sample 2
    v = '0; v.len = 8'd4; v.thr = 13'd1000; v.n = 3'd4;
    v.s[0] = l4(13'd10, 13'd20, 13'd30, 13'd40);
    v.s[1] = l4(13'h50, 13'h60, 13'h70, 13'h80);
    v.s[2] = l4(13'h11, 13'h22, 13'h1F00, 13'h33);
    v.s[3] = l4(13'hFF, 13'hFE, 13'hFD, 13'hFC);
    v.ev = 13'h1F00; v.el = 2'd2; v.ec = 8'd2; v.ea = 1'b1;
    vecs[0] = v;
    // 1: all lanes equal in all samples, threshold one above
    v = '0; v.len = 8'd3; v.thr = 13'h0801; v.n = 3'd3;
    for (int k = 0; k < 3; k++) v.s[k] = l4(13'h800, 13'h800, 13'h800, 13'h800);
    v.ev = 13'h800; v.el = 2'd0; v.ec = 8'd0; v.ea = 1'b0;
    vecs[1] = v;
    // 2: IN_VALID gap of two cycles, START pulsed in ACCUM (ignored)
    v = '0; v.len = 8'd2; v.thr = 13'd0; v.n = 3'd2; v.gap[1] = 2'd2; v.start_in_gap = 1'b1;
    v.s[0] = l4(13'd1, 13'd2, 13'd3, 13'd4);
    v.s[1] = l4(13'd5, 13'd6, 13'd7, 13'h1FFF);
    v.ev = 13'h1FFF; v.el = 2'd3; v.ec = 8'd1; v.ea = 1'b1;
    vecs[2] = v;
    // 3: all-zero window loads the first sample unconditionally
    v = '0; v.len = 8'd2; v.thr = 13'd0; v.n = 3'd2;
    v.ev = 13'd0; v.el = 2'd0; v.ec = 8'd0; v.ea = 1'b1;
    vecs[3] = v;
    // 4: tie between lanes 2 and 3 beats lanes 0/1, below threshold
    v = '0; v.len = 8'd1; v.thr = 13'd10; v.n = 3'd1;
    v.s[0] = l4(13'd5, 13'd5, 13'd9, 13'd9);
    v.ev = 13'd9; v.el = 2'd2; v.ec = 8'd0; v.ea = 1'b0;
    vecs[4] = v;
    // 5: equal peak later in time keeps the earlier one; threshold equal
    v = '0; v.len = 8'd3; v.thr = 13'h100; v.n = 3'd3;
    v.s[0] = l4(13'd0, 13'd0, 13'd0, 13'h100);
    v.s[1] = l4(13'h100, 13'd0, 13'd0, 13'd0);
    v.s[2] = l4(13'd0, 13'hFF, 13'd0, 13'd0);
    v.ev = 13'h100; v.el = 2'd3; v.ec = 8'd0; v.ea = 1'b1;
    vecs[5] = v;
    // 6: cross-pair tie goes to the lower pair (lane 1 over lane 2)
    v = '0; v.len = 8'd2; v.thr = 13'd9; v.n = 3'd2;
    v.s[0] = l4(13'd3, 13'd7, 13'd6, 13'd5);
    v.s[1] = l4(13'd8, 13'd9, 13'd9, 13'd9);
    v.ev = 13'd9; v.el = 2'd1; v.ec = 8'd1; v.ea = 1'b1;
    vecs[6] = v;

    // ---------------- reset then idle ----------------
    RST_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_pv", PEAK_VALID, 1'b0);
    chk("rst_outputs", {PEAK_VALUE, PEAK_LANE, PEAK_CYCLE, ABOVE_THRESH}, '0);
    RST_n = 1'b1;
    seen_pv = 0; seen_busy = 0; seen_out = 0;
    for (int i = 0; i < 12; i++) begin
      IN_VALID = i[0];
      drive_lanes(l4(13'(i * 100), 13'd7, 13'd8, 13'd9));
      tick();
      if (PEAK_VALID) seen_pv++;
      if (BUSY) seen_busy++;
      if ({PEAK_VALUE, PEAK_LANE, PEAK_CYCLE, ABOVE_THRESH} != '0) seen_out++;
    end
    IN_VALID = 1'b0;
    drive_lanes('0);
    chk("idle_no_pv", seen_pv, 0);
    chk("idle_no_busy", seen_busy, 0);
    chk("idle_outputs_zero", seen_out, 0);
    $display("reset_idle: pv_seen=%0d busy_seen=%0d", seen_pv, seen_busy);

    // ---------------- table-driven windows ----------------
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // ---------------- maximum window + back-to-back START ----------------
    START = 1'b1; WINDOW_LEN = 8'd0; THRESHOLD = 13'd0;
    tick();
    START = 1'b0;
    seen_busy = 0;
    for (int i = 0; i < 256; i++) begin
      drive_lanes(l4(13'(i), 13'd0, 13'd0, 13'd0));
      IN_VALID = 1'b1;
      tick();
      if (i < 255 && !BUSY) seen_busy++;
    end
    IN_VALID = 1'b0;
    drive_lanes('0);
    chk("maxwin_busy_held", seen_busy, 0);
    check_result("maxwin", 13'd255, 2'd0, 8'd255, 1'b1);
    // START in the PEAK_VALID cycle; sample presented immediately after.
    START = 1'b1; WINDOW_LEN = 8'd1; THRESHOLD = 13'h50;
    tick();
    START = 1'b0;
    chk("b2b_busy", BUSY, 1'b1);
    drive_lanes(l4(13'h10, 13'h50, 13'h30, 13'h50));
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    drive_lanes('0);
    check_result("b2b", 13'h50, 2'd1, 8'd0, 1'b1);
    tick();

    // ---------------- abort mid-window ----------------
    START = 1'b1; WINDOW_LEN = 8'd4; THRESHOLD = 13'd0;
    tick();
    START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_lanes(l4(13'h1000, 13'd1, 13'd2, 13'd3));
      IN_VALID = 1'b1;
      tick();
    end
    IN_VALID = 1'b0;
    RST_n = 1'b0;
    #1;
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_outputs", {PEAK_VALUE, PEAK_LANE, ABOVE_THRESH}, '0);
    tick();
    tick();
    RST_n = 1'b1;
    seen_pv = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (PEAK_VALID || BUSY) seen_pv++;
    end
    chk("abort_no_pv", seen_pv, 0);
    $display("abort: busy=%0b pv_seen=%0d", BUSY, seen_pv);
    v = '0; v.len = 8'd1; v.thr = 13'h41; v.n = 3'd1;
    v.s[0] = l4(13'h10, 13'h20, 13'h30, 13'h40);
    v.ev = 13'h40; v.el = 2'd3; v.ec = 8'd0; v.ea = 1'b0;
    run_vec(v, "post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
